ps2_device_tx: RTL and testbench



---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_sync.sv | 21 ++
 rtl/ps2_device_tx.sv | 148 ++++++++++++++
 tb/tb_ps2_device_tx.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM states, frame constants and the frame builder
// used by the device-side transmitter.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    HIGH,
    LOW,
    ABORT,
    GAP
  } ps2_state_t;

  localparam int PS2_FRAME_BITS     = 11;
  localparam int PS2_INHIBIT_SETTLE = 4;
  localparam int PS2_GAP_HALVES     = 2;

  // Bit 0 goes on the wire first: start, data LSB..MSB, odd parity, stop.
  function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchroniser for a sensed PS/2 line; resets to the idle-high level.
module ps2_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter: generates the PS/2 clock, serialises one
// scan-code frame per accepted byte and restarts the frame on host inhibit.
module ps2_device_tx
  import ps2_pkg::*;
#(
  parameter int CLKFREQ     = 16000,
  parameter int PS2_HALF_US = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       done,
  output logic       abort,
  input  logic       ps2clk_in,
  output logic       ps2clk_oe,
  output logic       ps2dat_oe
);

  localparam int HALF = CLKFREQ * PS2_HALF_US / 1000;
  localparam int CW   = $clog2(2 * HALF);

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(PS2_GAP_HALVES * HALF - 1);
  localparam logic [CW-1:0] SETTLE    = CW'(PS2_INHIBIT_SETTLE);
  localparam logic [3:0]    LAST_BIT  = 4'(PS2_FRAME_BITS - 1);

  ps2_state_t                state, state_n;
  logic [CW-1:0]             cnt, cnt_n;
  logic [3:0]                idx, idx_n;
  logic [PS2_FRAME_BITS-1:0] shreg;
  logic                      done_q;
  logic                      load;
  logic                      gap_end;
  logic                      clk_sync;

  ps2_sync u_clk_sync (
    .clk (clk),
    .rst (rst),
    .d   (ps2clk_in),
    .q   (clk_sync)
  );

  // done is registered, so ready is held off for its pulse cycle.
  assign ready = (state == IDLE) && !done_q;
  assign done  = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      shreg  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      done_q <= gap_end;
      if (load) shreg <= ps2_frame(data);
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    load      = 1'b0;
    gap_end   = 1'b0;
    abort     = 1'b0;
    ps2clk_oe = 1'b0;
    ps2dat_oe = 1'b0;

    unique case (state)
      IDLE: begin
        if (valid && ready) begin
          load    = 1'b1;
          cnt_n   = '0;
          state_n = WAIT;
        end
      end

      // The clock line must read high for a full half period before we start.
      WAIT: begin
        if (!clk_sync) begin
          cnt_n = '0;
        end else if (cnt == HALF_LAST) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = HIGH;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      // Early samples still see our own LOW drive through the synchroniser.
      HIGH: begin
        ps2dat_oe = ~shreg[idx];
        if (cnt >= SETTLE && !clk_sync) begin
          cnt_n   = '0;
          state_n = ABORT;
        end else if (cnt == HALF_LAST) begin
          cnt_n   = '0;
          state_n = LOW;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      LOW: begin
        ps2clk_oe = 1'b1;
        ps2dat_oe = ~shreg[idx];
        if (cnt == HALF_LAST) begin
          cnt_n = '0;
          if (idx == LAST_BIT) begin
            state_n = GAP;
          end else begin
            idx_n   = idx + 4'd1;
            state_n = HIGH;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      ABORT: begin
        abort   = 1'b1;
        cnt_n   = '0;
        idx_n   = '0;
        state_n = WAIT;
      end

      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_n   = '0;
          gap_end = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Self-checking bench for ps2_device_tx: scenario tasks compare the wire
// activity against a framing/timing model derived from the PS/2 protocol rules.
module tb_ps2_device_tx;

  localparam int CLKFREQ     = 16000;
  localparam int PS2_HALF_US = 4;
  localparam int HALF        = CLKFREQ * PS2_HALF_US / 1000;
  localparam int FRAME_CYC   = 25 * HALF;
  localparam int INHIBIT_CYC = 200 * CLKFREQ / 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic       ready, done, abort;
  logic       ps2clk_in, ps2clk_oe, ps2dat_oe;
  logic       host_low = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int   fall_q[$];
  int   rise_q[$];
  logic bit_q[$];
  int   done_cnt = 0;
  int   abort_cnt = 0;
  int   last_abort = 0;
  logic prev_clk_oe = 1'b0;
  logic prev_dat_oe = 1'b0;

  // Open-drain clock line with pull-up: low if either end pulls it.
  assign ps2clk_in = ~(ps2clk_oe | host_low);

  ps2_device_tx #(
    .CLKFREQ     (CLKFREQ),
    .PS2_HALF_US (PS2_HALF_US)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .done      (done),
    .abort     (abort),
    .ps2clk_in (ps2clk_in),
    .ps2clk_oe (ps2clk_oe),
    .ps2dat_oe (ps2dat_oe)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Wire monitor: records device-driven clock edges and the data seen at each fall.
  always @(negedge clk) begin
    if (!prev_clk_oe && ps2clk_oe) begin
      fall_q.push_back(cyc);
      bit_q.push_back(~ps2dat_oe);
    end
    if (prev_clk_oe && !ps2clk_oe) rise_q.push_back(cyc);
    if (prev_clk_oe && ps2clk_oe) begin
      checks++;
      if (ps2dat_oe !== prev_dat_oe) begin
        errors++;
        $display("[TB] FAIL data_stable: data oe changed to %b while clock low at cycle %0d (required %b)",
                 ps2dat_oe, cyc, prev_dat_oe);
      end
    end
    if (done) done_cnt++;
    if (abort) begin
      abort_cnt++;
      last_abort = cyc;
    end
    if (done || abort) begin
      checks++;
      if (done && abort) begin
        errors++;
        $display("[TB] FAIL done_abort_exclusive: done=%b abort=%b at cycle %0d, required not both", done, abort, cyc);
      end
    end
    prev_clk_oe = ps2clk_oe;
    prev_dat_oe = ps2dat_oe;
  end

  // Reference framing: start 0, data LSB first, parity making the one-count odd, stop 1.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = (($countones(b) % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  function automatic logic [10:0] captured(input int first);
    logic [10:0] c;
    for (int i = 0; i < 11; i++)
      c[i] = (first + i < bit_q.size()) ? bit_q[first + i] : 1'bx;
    return c;
  endfunction

  task automatic clear_capture();
    fall_q.delete();
    rise_q.delete();
    bit_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, output int acc);
    int n;
    n = 0;
    while (!ready && n < 4 * FRAME_CYC) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: ready=%b after %0d cycles, required 1", ready, n);
    end
    data  = b;
    valid = 1'b1;
    @(posedge clk); #1;
    acc   = cyc;
    valid = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int at);
    int n;
    n = 0;
    while (!done && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    at = cyc;
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: done=%b after %0d cycles, required 1", done, n);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    valid = 1'b1;
    data  = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    checks += 5;
    if (ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b required 1", ready); end
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b required 0", done); end
    if (abort !== 1'b0) begin errors++; $display("[TB] FAIL reset_abort: got %b required 0", abort); end
    if (ps2clk_oe !== 1'b0) begin errors++; $display("[TB] FAIL reset_clk_oe: got %b required 0", ps2clk_oe); end
    if (ps2dat_oe !== 1'b0) begin errors++; $display("[TB] FAIL reset_dat_oe: got %b required 0", ps2dat_oe); end
    valid = 1'b0;
    rst   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b1 || ps2clk_oe !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: ready=%b clk_oe=%b required 1/0", ready, ps2clk_oe);
    end
  endtask

  task automatic test_frame(input logic [7:0] b);
    int acc, at;
    logic [10:0] exp_f, got_f;
    clear_capture();
    send_byte(b, acc);
    wait_done(FRAME_CYC + 16, at);
    exp_f = model_frame(b);
    got_f = captured(0);
    checks += 4;
    if (at !== acc + FRAME_CYC) begin
      errors++;
      $display("[TB] FAIL done_time_%02h: done at %0d required %0d", b, at, acc + FRAME_CYC);
    end
    if (ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ready_with_done_%02h: got %b required 0", b, ready);
    end
    if (bit_q.size() != 11 || rise_q.size() != 11) begin
      errors++;
      $display("[TB] FAIL edge_count_%02h: falls %0d rises %0d required 11", b, bit_q.size(), rise_q.size());
    end
    if (got_f !== exp_f) begin
      errors++;
      $display("[TB] FAIL frame_%02h: got %b required %b (bit0 rightmost)", b, got_f, exp_f);
    end
    if (fall_q.size() == 11 && rise_q.size() == 11) begin
      checks++;
      if (fall_q[0] != acc + 2 * HALF) begin
        errors++;
        $display("[TB] FAIL first_fall_%02h: at %0d required %0d", b, fall_q[0], acc + 2 * HALF);
      end
      for (int k = 0; k < 11; k++) begin
        checks++;
        if (rise_q[k] - fall_q[k] != HALF) begin
          errors++;
          $display("[TB] FAIL low_len_%02h_bit%0d: got %0d required %0d", b, k, rise_q[k] - fall_q[k], HALF);
        end
        if (k > 0) begin
          checks++;
          if (fall_q[k] - fall_q[k-1] != 2 * HALF) begin
            errors++;
            $display("[TB] FAIL bit_period_%02h_bit%0d: got %0d required %0d", b, k,
                     fall_q[k] - fall_q[k-1], 2 * HALF);
          end
        end
      end
    end
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ready_after_done_%02h: ready=%b done=%b required 1/0", b, ready, done);
    end
  endtask

  task automatic test_host_held();
    int acc, at, rel;
    host_low = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    clear_capture();
    send_byte(8'h5A, acc);
    repeat (5000) @(posedge clk);
    #1;
    checks++;
    if (fall_q.size() != 0 || ps2clk_oe !== 1'b0) begin
      errors++;
      $display("[TB] FAIL held_no_clock: falls %0d clk_oe=%b required 0/0", fall_q.size(), ps2clk_oe);
    end
    host_low = 1'b0;
    rel = cyc;
    wait_done(FRAME_CYC + 64, at);
    checks += 3;
    if (fall_q.size() == 0 || fall_q[0] != rel + 2 * HALF + 2) begin
      errors++;
      $display("[TB] FAIL held_first_fall: at %0d required %0d",
               (fall_q.size() == 0) ? -1 : fall_q[0], rel + 2 * HALF + 2);
    end
    if (captured(0) !== model_frame(8'h5A)) begin
      errors++;
      $display("[TB] FAIL held_frame: got %b required %b", captured(0), model_frame(8'h5A));
    end
    if (at != rel + 2 + FRAME_CYC) begin
      errors++;
      $display("[TB] FAIL held_done_time: at %0d required %0d", at, rel + 2 + FRAME_CYC);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    int acc, at, p, rel, d0, a0;
    bit released;
    clear_capture();
    d0 = done_cnt;
    a0 = abort_cnt;
    send_byte(8'h1C, acc);
    repeat (11 * HALF + 10) @(posedge clk);
    #1;
    host_low = 1'b1;
    p = cyc;
    released = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (ps2clk_oe === 1'b0 && ps2dat_oe === 1'b0 && abort === 1'b1) released = 1'b1;
    end
    checks += 2;
    if (!released || ps2clk_oe !== 1'b0 || ps2dat_oe !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_release: clk_oe=%b dat_oe=%b seen=%b required 0/0/1",
               ps2clk_oe, ps2dat_oe, released);
    end
    if (bit_q.size() != 5) begin
      errors++;
      $display("[TB] FAIL abort_bits_before: got %0d falls required 5", bit_q.size());
    end
    @(posedge clk); #1;
    checks += 2;
    if (abort !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_one_cycle: abort=%b one cycle later, required 0", abort);
    end
    if (abort_cnt - a0 != 1 || last_abort <= p || last_abort > p + 3) begin
      errors++;
      $display("[TB] FAIL abort_pulse: count %0d at %0d required 1 within (%0d,%0d]",
               abort_cnt - a0, last_abort, p, p + 3);
    end
    repeat (INHIBIT_CYC - 4) @(posedge clk);
    #1;
    clear_capture();
    host_low = 1'b0;
    rel = cyc;
    wait_done(FRAME_CYC + 64, at);
    @(posedge clk); #1;
    checks += 4;
    if (captured(0) !== model_frame(8'h1C) || bit_q.size() != 11) begin
      errors++;
      $display("[TB] FAIL abort_resend_frame: got %b (%0d bits) required %b",
               captured(0), bit_q.size(), model_frame(8'h1C));
    end
    if (fall_q.size() == 0 || fall_q[0] != rel + 2 * HALF + 2) begin
      errors++;
      $display("[TB] FAIL abort_resend_first_fall: at %0d required %0d",
               (fall_q.size() == 0) ? -1 : fall_q[0], rel + 2 * HALF + 2);
    end
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("[TB] FAIL abort_done_count: got %0d required 1", done_cnt - d0);
    end
    if (abort_cnt - a0 != 1) begin
      errors++;
      $display("[TB] FAIL abort_count_total: got %0d required 1", abort_cnt - a0);
    end
  endtask

  task automatic test_back_to_back();
    int acc1, acc2, d1, d2;
    clear_capture();
    data  = 8'hF0;
    valid = 1'b1;
    @(posedge clk); #1;
    acc1 = cyc;
    data = 8'h1C;
    wait_done(FRAME_CYC + 16, d1);
    checks++;
    if (d1 != acc1 + FRAME_CYC || ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_first_done: at %0d ready=%b required %0d/0", d1, ready, acc1 + FRAME_CYC);
    end
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_ready_rise: got %b required 1", ready);
    end
    @(posedge clk); #1;
    acc2  = cyc;
    valid = 1'b0;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_second_accept: ready=%b one cycle after rising, required 0", ready);
    end
    wait_done(FRAME_CYC + 16, d2);
    @(posedge clk); #1;
    checks += 4;
    if (bit_q.size() != 22 || rise_q.size() != 22) begin
      errors++;
      $display("[TB] FAIL b2b_edge_count: falls %0d rises %0d required 22", bit_q.size(), rise_q.size());
    end
    if (captured(0) !== model_frame(8'hF0)) begin
      errors++;
      $display("[TB] FAIL b2b_frame_f0: got %b required %b", captured(0), model_frame(8'hF0));
    end
    if (captured(11) !== model_frame(8'h1C)) begin
      errors++;
      $display("[TB] FAIL b2b_frame_1c: got %b required %b", captured(11), model_frame(8'h1C));
    end
    if (d2 != acc2 + FRAME_CYC) begin
      errors++;
      $display("[TB] FAIL b2b_second_done: at %0d required %0d", d2, acc2 + FRAME_CYC);
    end
    if (fall_q.size() >= 12 && rise_q.size() >= 11) begin
      checks++;
      if (fall_q[11] - rise_q[10] < 4 * HALF) begin
        errors++;
        $display("[TB] FAIL b2b_inter_frame_gap: got %0d required at least %0d",
                 fall_q[11] - rise_q[10], 4 * HALF);
      end
    end
  endtask

  task automatic test_reset_mid();
    int acc, d0;
    clear_capture();
    d0 = done_cnt;
    send_byte(8'h3C, acc);
    repeat (8 * HALF + 10) @(posedge clk);
    #1;
    checks++;
    if (ps2clk_oe !== 1'b1 || bit_q.size() != 4) begin
      errors++;
      $display("[TB] FAIL mid_bit3_low: clk_oe=%b falls %0d required 1/4", ps2clk_oe, bit_q.size());
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (ps2clk_oe !== 1'b0 || ps2dat_oe !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL async_reset_release: clk_oe=%b dat_oe=%b ready=%b required 0/0/1",
               ps2clk_oe, ps2dat_oe, ready);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_capture();
    repeat (FRAME_CYC) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != d0 || fall_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL reset_discard: done count %0d falls %0d required 0/0", done_cnt - d0, fall_q.size());
    end
    test_frame(8'hA5);
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(0, 255));
      test_frame(b);
    end
  endtask

  initial begin
    #(2000000 * 10);
    errors++;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_frame(8'h1C);
    test_frame(8'h00);
    test_host_held();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
